switch_scheduler: RTL and testbench

//  Sequences the three input FIFOs and three output muxes of the 3x3 packet switch.

---
 rtl/switch_scheduler_if.sv | 27 ++
 rtl/switch_scheduler.sv | 159 +++++++++++++++
 tb/tb_switch_scheduler.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/switch_scheduler_if.sv
// Handshake bundle between the 3x3 switch scheduler and its FIFO/megamux datapath.
interface switch_scheduler_if #(
    parameter int CNT_W = 8
);
    logic [2:0]       fifo_empty;
    logic [7:0]       head1;
    logic [7:0]       head2;
    logic [7:0]       head3;
    logic [2:0]       out_ready;
    logic [2:0]       rdreq;
    logic [2:0]       sel1;
    logic [2:0]       sel2;
    logic [2:0]       sel3;
    logic [2:0]       xfer_valid;
    logic [CNT_W-1:0] drop_count;
    logic             busy;

    modport master (
        input  fifo_empty, head1, head2, head3, out_ready,
        output rdreq, sel1, sel2, sel3, xfer_valid, drop_count, busy
    );

    modport slave (
        output fifo_empty, head1, head2, head3, out_ready,
        input  rdreq, sel1, sel2, sel3, xfer_valid, drop_count, busy
    );
endinterface

// File: rtl/switch_scheduler.sv
// 3x3 packet switch scheduler: decodes FIFO head destinations, round-robin arbitrates
// each output, then dequeues winners and steers the output muxes for one cycle.

module sched_out_arb (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] req,    // bit i = FIFO i+1 wants this output
    input  logic       ready,
    input  logic       arb,
    output logic [1:0] gnt,    // winning FIFO index, 0 = none
    output logic [2:0] sel,
    output logic       vld
);
    logic [1:0] rr_last;
    int         idx;

    always_comb begin
        gnt = 2'd0;
        idx = 0;
        if (ready) begin
            for (int k = 1; k <= 3; k++) begin
                idx = ((int'(rr_last) + k - 1) % 3) + 1;
                if (gnt == 2'd0 && req[idx-1]) gnt = 2'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_last <= 2'd3;
            sel     <= 3'd0;
            vld     <= 1'b0;
        end else begin
            sel <= arb ? {1'b0, gnt} : 3'd0;
            vld <= arb && (gnt != 2'd0);
            if (arb && gnt != 2'd0) rr_last <= gnt;
        end
    end
endmodule

module switch_scheduler #(
    parameter int HOLD_CYCLES = 4,
    parameter int DEST_MSB    = 7,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    switch_scheduler_if.master bus
);
    typedef enum logic [1:0] {IDLE, ARB, XFER, HOLD} state_t;

    localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W+1:0] CNT_MAX = {2'b00, {CNT_W{1'b1}}};

    state_t            state_q, state_d;
    logic [HC_W-1:0]   hold_cnt, hold_d;
    logic [2:0][7:0]   head;
    logic [2:0][1:0]   dest;
    logic [2:0][2:0]   req;      // req[j][i]: FIFO i+1 targets output j+1
    logic [2:0]        drop;
    logic [1:0]        n_drop;
    logic [2:0][1:0]   gnt;
    logic [2:0][2:0]   sel;
    logic [2:0]        xv;
    logic [2:0]        rd_set;
    logic [2:0]        rdreq_q;
    logic [CNT_W-1:0]  drop_cnt;
    logic [CNT_W+1:0]  drop_sum;
    logic              busy_q;
    logic              arb;
    logic              unused_head;

    assign head        = {bus.head3, bus.head2, bus.head1};
    assign unused_head = ^head;
    assign arb         = (state_q == ARB);

    always_comb begin
        dest   = '0;
        req    = '0;
        drop   = '0;
        for (int i = 0; i < 3; i++) begin
            dest[i] = head[i][DEST_MSB -: 2];
            drop[i] = !bus.fifo_empty[i] && dest[i] == 2'd0;
            for (int j = 0; j < 3; j++)
                req[j][i] = !bus.fifo_empty[i] && dest[i] == 2'(j + 1);
        end
    end

    genvar j;
    generate
        for (j = 0; j < 3; j++) begin : g_out
            sched_out_arb u_arb (
                .clk   (clk),
                .reset (reset),
                .req   (req[j]),
                .ready (bus.out_ready[j]),
                .arb   (arb),
                .gnt   (gnt[j]),
                .sel   (sel[j]),
                .vld   (xv[j])
            );
        end
    endgenerate

    // A FIFO targets one output only, so grants never collide on rd_set bits.
    always_comb begin
        rd_set = drop;
        for (int k = 0; k < 3; k++)
            if (gnt[k] != 2'd0) rd_set[int'(gnt[k]) - 1] = 1'b1;
        n_drop   = 2'(drop[0]) + 2'(drop[1]) + 2'(drop[2]);
        drop_sum = {2'b00, drop_cnt} + (CNT_W+2)'(n_drop);
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_cnt;
        case (state_q)
            IDLE: if (|(~bus.fifo_empty)) state_d = ARB;
            ARB:  state_d = XFER;
            XFER: begin
                if (HOLD_CYCLES > 0) begin
                    state_d = HOLD;
                    hold_d  = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (hold_cnt == HC_W'(HOLD_CYCLES - 1)) state_d = IDLE;
                else hold_d = hold_cnt + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            hold_cnt <= '0;
            rdreq_q  <= 3'd0;
            drop_cnt <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_cnt <= hold_d;
            rdreq_q  <= arb ? rd_set : 3'd0;
            busy_q   <= (state_d != IDLE);
            if (arb) drop_cnt <= (drop_sum > CNT_MAX) ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
        end
    end

    assign bus.rdreq      = rdreq_q;
    assign bus.sel1       = sel[0];
    assign bus.sel2       = sel[1];
    assign bus.sel3       = sel[2];
    assign bus.xfer_valid = xv;
    assign bus.drop_count = drop_cnt;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_switch_scheduler.sv
// Directed bench for switch_scheduler with behavioural show-ahead FIFOs on the inputs.
module tb_switch_scheduler;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    switch_scheduler_if #(.CNT_W(2)) bus ();

    switch_scheduler #(.HOLD_CYCLES(4), .DEST_MSB(7), .CNT_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] q1[$];
    logic [7:0] q2[$];
    logic [7:0] q3[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        bus.fifo_empty = {q3.size() == 0, q2.size() == 0, q1.size() == 0};
        bus.head1 = (q1.size() != 0) ? q1[0] : 8'h00;
        bus.head2 = (q2.size() != 0) ? q2[0] : 8'h00;
        bus.head3 = (q3.size() != 0) ? q3[0] : 8'h00;
    endtask

    // FIFOs act on the rdreq seen during the current cycle at the next edge.
    task automatic tick();
        logic [2:0] rd;
        rd = bus.rdreq;
        @(posedge clk);
        #1;
        if (rd[0] && q1.size() != 0) void'(q1.pop_front());
        if (rd[1] && q2.size() != 0) void'(q2.pop_front());
        if (rd[2] && q3.size() != 0) void'(q3.pop_front());
        drive();
    endtask

    // Starts in an IDLE cycle with heads present; ends in the IDLE cycle after HOLD.
    task automatic round(input string tag, input logic [2:0] e_rd, input logic [2:0] e_s1,
                         input logic [2:0] e_s2, input logic [2:0] e_s3,
                         input logic [2:0] e_xv, input logic [1:0] e_drop);
        tick();
        chk({tag, " arb busy"}, 32'(bus.busy), 32'd1);
        chk({tag, " arb rdreq"}, 32'(bus.rdreq), 32'd0);
        tick();
        chk({tag, " rdreq"}, 32'(bus.rdreq), 32'(e_rd));
        chk({tag, " sel1"}, 32'(bus.sel1), 32'(e_s1));
        chk({tag, " sel2"}, 32'(bus.sel2), 32'(e_s2));
        chk({tag, " sel3"}, 32'(bus.sel3), 32'(e_s3));
        chk({tag, " xfer_valid"}, 32'(bus.xfer_valid), 32'(e_xv));
        chk({tag, " drop_count"}, 32'(bus.drop_count), 32'(e_drop));
        for (int k = 0; k < 4; k++) begin
            tick();
            chk({tag, " hold rdreq"}, 32'(bus.rdreq), 32'd0);
            chk({tag, " hold busy"}, 32'(bus.busy), 32'd1);
        end
        tick();
        chk({tag, " idle busy"}, 32'(bus.busy), 32'd0);
        chk({tag, " idle xfer_valid"}, 32'(bus.xfer_valid), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        bus.out_ready = 3'b111;
        drive();
        repeat (2) @(posedge clk);
        #1;
        chk("rst rdreq", 32'(bus.rdreq), 32'd0);
        chk("rst sel1", 32'(bus.sel1), 32'd0);
        chk("rst xfer_valid", 32'(bus.xfer_valid), 32'd0);
        chk("rst drop_count", 32'(bus.drop_count), 32'd0);
        chk("rst busy", 32'(bus.busy), 32'd0);
        reset = 1'b0;

        // single head to output 1
        q1.push_back(8'h45);
        drive();
        round("t1", 3'b001, 3'd1, 3'd0, 3'd0, 3'b001, 2'd0);

        // three FIFOs contend for output 2, FIFO1 refilled
        q1.push_back(8'h81); q1.push_back(8'h84);
        q2.push_back(8'h82); q3.push_back(8'h83);
        drive();
        round("t2r1", 3'b001, 3'd0, 3'd1, 3'd0, 3'b010, 2'd0);
        round("t2r2", 3'b010, 3'd0, 3'd2, 3'd0, 3'b010, 2'd0);
        round("t2r3", 3'b100, 3'd0, 3'd3, 3'd0, 3'b010, 2'd0);
        round("t2r4", 3'b001, 3'd0, 3'd1, 3'd0, 3'b010, 2'd0);

        // all three outputs in one round
        q1.push_back(8'h41); q2.push_back(8'h82); q3.push_back(8'hC3);
        drive();
        round("t3", 3'b111, 3'd1, 3'd2, 3'd3, 3'b111, 2'd0);

        // output 3 not ready: nothing issued, head retained
        bus.out_ready = 3'b011;
        q2.push_back(8'hC7);
        drive();
        round("t4a", 3'b000, 3'd0, 3'd0, 3'd0, 3'b000, 2'd0);
        chk("t4 fifo2 kept", 32'(q2.size()), 32'd1);
        bus.out_ready = 3'b111;
        round("t4b", 3'b010, 3'd0, 3'd0, 3'd2, 3'b100, 2'd0);

        // drops saturate a 2-bit counter
        q1.push_back(8'h05); q1.push_back(8'h11); q1.push_back(8'h2A);
        q1.push_back(8'h3F); q1.push_back(8'h00);
        drive();
        round("t5d1", 3'b001, 3'd0, 3'd0, 3'd0, 3'b000, 2'd1);
        round("t5d2", 3'b001, 3'd0, 3'd0, 3'd0, 3'b000, 2'd2);
        round("t5d3", 3'b001, 3'd0, 3'd0, 3'd0, 3'b000, 2'd3);
        round("t5d4", 3'b001, 3'd0, 3'd0, 3'd0, 3'b000, 2'd3);
        round("t5d5", 3'b001, 3'd0, 3'd0, 3'd0, 3'b000, 2'd3);

        // reset in XFER aborts the dequeue
        q1.push_back(8'h4A);
        drive();
        tick();
        tick();
        chk("t6 xfer rdreq", 32'(bus.rdreq), 32'b001);
        chk("t6 xfer sel1", 32'(bus.sel1), 32'd1);
        reset = 1'b1;
        #1;
        chk("t6 rst rdreq", 32'(bus.rdreq), 32'd0);
        chk("t6 rst sel1", 32'(bus.sel1), 32'd0);
        chk("t6 rst xfer_valid", 32'(bus.xfer_valid), 32'd0);
        chk("t6 rst busy", 32'(bus.busy), 32'd0);
        chk("t6 rst drop_count", 32'(bus.drop_count), 32'd0);
        tick();
        reset = 1'b0;
        chk("t6 fifo1 intact", 32'(q1.size()), 32'd1);
        // rr_last restored to 3: FIFO1 beats FIFO2 for output 1
        q2.push_back(8'h4B);
        drive();
        round("t6r1", 3'b001, 3'd1, 3'd0, 3'd0, 3'b001, 2'd0);
        round("t6r2", 3'b010, 3'd2, 3'd0, 3'd0, 3'b001, 2'd0);

        // two drops and one transfer in the same round
        q1.push_back(8'h00); q2.push_back(8'h3C); q3.push_back(8'h55);
        drive();
        round("t7", 3'b111, 3'd3, 3'd0, 3'd0, 3'b001, 2'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
